// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and registered 4:1 data mux for a shared WIDTH-bit channel.
// Latency: grant/select one cycle after req is sampled; out/out_valid one cycle after grant.
// Backpressure: none downstream; fairness comes from a bounded grant hold (MAX_HOLD) while others wait.
module mux_rr_arbiter #(
    parameter int WIDTH    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    output logic [3:0]       grant,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t           state_q,     state_d;
    logic [1:0]       last_q,      last_d;
    logic [3:0]       hold_cnt_q,  hold_cnt_d;
    logic [3:0]       grant_q,     grant_d;
    logic [1:0]       select_q,    select_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic             out_valid_q, out_valid_d;

    // Search r starting at index start and wrapping; returns {found, index}.
    // Iterating from the far end down lets the closest set bit overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [2:0]       idle_pick;
    logic [2:0]       sw_pick;
    logic [3:0]       others;
    logic             cur_req;
    logic [WIDTH-1:0] sel_word;

    // Candidate winners: from IDLE search after the last-served requester;
    // while granted, search after the current owner among the other requesters only.
    always_comb begin
        others    = req & ~(4'b0001 << select_q);
        cur_req   = req[select_q];
        idle_pick = rr_pick(req, last_q + 2'd1);
        sw_pick   = rr_pick(others, select_q + 2'd1);
    end

    // Shared data mux, driven only by the registered select.
    always_comb begin
        sel_word = in1;
        case (select_q)
            2'd0:    sel_word = in1;
            2'd1:    sel_word = in2;
            2'd2:    sel_word = in3;
            default: sel_word = in4;
        endcase
    end

    // Next-state logic: arbitration FSM plus the registered data path.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        grant_d     = grant_q;
        select_d    = select_q;
        out_valid_d = (state_q == GRANT) && cur_req;
        out_d       = out_valid_d ? sel_word : out_q;

        case (state_q)
            IDLE: begin
                if (idle_pick[2]) begin
                    state_d    = GRANT;
                    grant_d    = 4'b0001 << idle_pick[1:0];
                    select_d   = idle_pick[1:0];
                    hold_cnt_d = 4'd1;
                end
            end
            GRANT: begin
                if (sw_pick[2] && (!cur_req || hold_cnt_q == MAX_HOLD_C)) begin
                    // Owner released or used up its hold while someone waits:
                    // hand over on this edge, no idle bubble.
                    last_d     = select_q;
                    grant_d    = 4'b0001 << sw_pick[1:0];
                    select_d   = sw_pick[1:0];
                    hold_cnt_d = 4'd1;
                end else if (!cur_req) begin
                    // Nobody left; select keeps its value for the idle period.
                    state_d    = IDLE;
                    last_d     = select_q;
                    grant_d    = 4'b0000;
                    hold_cnt_d = 4'd0;
                end else if (hold_cnt_q != MAX_HOLD_C) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 2'd3;
            hold_cnt_q  <= 4'd0;
            grant_q     <= 4'b0000;
            select_q    <= 2'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            select_q    <= select_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign grant     = grant_q;
    assign select    = select_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: behavioural model feeds a scoreboard queue.
// Latency: each stimulus cycle pushes expected outputs, popped 1ns after the edge.
// Backpressure: not applicable.
module tb_mux_rr_arbiter;

    localparam int WIDTH    = 2;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] in1, in2, in3, in4;
    logic [3:0]       grant;
    logic [1:0]       select;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .grant     (grant),
        .select    (select),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic [1:0] out;
        logic       ov;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    logic       m_busy;
    int         m_last;
    int         m_hold;
    int         m_sel;
    logic [3:0] m_grant;
    logic [1:0] m_out;
    logic       m_ov;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start, input int excl);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (start + k) % 4;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_edge(input logic r, input logic [3:0] rq, input logic [1:0] d[4]);
        int   w;
        int   s;
        logic nov;
        if (r) begin
            m_busy = 0; m_last = 3; m_hold = 0; m_sel = 0;
            m_grant = 4'b0000; m_out = 2'd0; m_ov = 0;
            return;
        end
        nov = m_busy && rq[m_sel];
        if (nov) m_out = d[m_sel];
        m_ov = nov;
        if (!m_busy) begin
            w = pick(rq, (m_last + 1) % 4, -1);
            if (w >= 0) begin
                m_busy = 1; m_sel = w; m_grant = 4'(1 << w); m_hold = 1;
            end
        end else begin
            s = m_sel;
            w = pick(rq, (s + 1) % 4, s);
            if (w >= 0 && (!rq[s] || m_hold == MAX_HOLD)) begin
                m_last = s; m_sel = w; m_grant = 4'(1 << w); m_hold = 1;
            end else if (!rq[s]) begin
                m_busy = 0; m_grant = 4'b0000; m_last = s; m_hold = 0;
            end else if (m_hold < MAX_HOLD) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
        logic [1:0] dv[4];
        exp_t       e;
        rst = r; req = rq; in1 = a; in2 = b; in3 = c; in4 = d;
        dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
        model_edge(r, rq, dv);
        e.grant = m_grant; e.sel = 2'(m_sel); e.out = m_out; e.ov = m_ov; e.busy = m_busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("grant",     8'(grant),     8'(e.grant));
        chk("select",    8'(select),    8'(e.sel));
        chk("out",       8'(out),       8'(e.out));
        chk("out_valid", 8'(out_valid), 8'(e.ov));
        chk("busy",      8'(busy),      8'(e.busy));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'b1111, 2'd0, 2'd1, 2'd2, 2'd3);
    endtask

    logic [3:0] exp_g;
    logic [1:0] ra, rb, rc, rd;

    initial begin
        rst = 1'b1; req = 4'b0; in1 = '0; in2 = '0; in3 = '0; in4 = '0;
        m_busy = 0; m_last = 3; m_hold = 0; m_sel = 0;
        m_grant = 4'b0; m_out = 2'd0; m_ov = 0;
        @(negedge clk);

        // reset with all requests high
        do_reset(2);
        chk("rst_grant", 8'(grant), 8'h00);
        chk("rst_busy",  8'(busy),  8'h00);
        chk("rst_out",   8'(out),   8'h00);
        step(1'b0, 4'b1111, 2'd0, 2'd1, 2'd2, 2'd3);
        chk("first_grant", 8'(grant), 8'h01);
        chk("first_sel",   8'(select), 8'h00);

        // single requester keeps its grant
        do_reset(1);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'b0100, 2'd0, 2'd0, 2'b10, 2'd0);
            chk("single_grant", 8'(grant), 8'h04);
            if (k > 0) chk("single_out", 8'({out_valid, out}), 8'h06);
        end

        // fairness with everyone requesting
        do_reset(1);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'b1111, 2'd0, 2'd1, 2'd2, 2'd3);
            exp_g = 4'b0001 << ((k / MAX_HOLD) % 4);
            chk("fair_grant", 8'(grant), 8'(exp_g));
        end

        // early release handover, then go idle
        do_reset(1);
        step(1'b0, 4'b0010, 2'd0, 2'd1, 2'd2, 2'd3);
        chk("er_grant1", 8'(grant), 8'h02);
        step(1'b0, 4'b1001, 2'd0, 2'd1, 2'd2, 2'd3);
        chk("er_grant3", 8'(grant), 8'h08);
        step(1'b0, 4'b1000, 2'd0, 2'd1, 2'd2, 2'd3);
        step(1'b0, 4'b0000, 2'd0, 2'd1, 2'd2, 2'd3);
        step(1'b0, 4'b0000, 2'd0, 2'd1, 2'd2, 2'd3);
        chk("er_idle", 8'({grant, busy, out_valid}), 8'h00);
        chk("er_hold_out", 8'(out), 8'h03);

        // reset in the middle of a grant
        do_reset(1);
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0100, 2'd0, 2'd1, 2'd2, 2'd3);
        step(1'b1, 4'b0110, 2'd0, 2'd1, 2'd2, 2'd3);
        chk("mid_rst_grant", 8'(grant), 8'h00);
        step(1'b0, 4'b0110, 2'd0, 2'd1, 2'd2, 2'd3);
        chk("mid_rst_after", 8'(grant), 8'h02);

        // non-selected inputs must not disturb out
        do_reset(1);
        step(1'b0, 4'b0001, 2'd1, 2'd0, 2'd0, 2'd0);
        for (int k = 0; k < 8; k++) begin
            ra = 2'($urandom_range(3)); rb = 2'($urandom_range(3));
            rc = 2'($urandom_range(3)); rd = 2'($urandom_range(3));
            step(1'b0, 4'b0001, ra, rb, rc, rd);
            chk("iso_out", 8'(out), 8'(ra));
        end

        // random traffic against the model
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(40) == 0), 4'($urandom_range(15)),
                 2'($urandom_range(3)), 2'($urandom_range(3)),
                 2'($urandom_range(3)), 2'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got=running expected=done");
        $fatal(1);
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1, 2-bit data mux.
- Four requesters each present a 2-bit word plus a request line.
- The block grants one requester at a time, drives the mux select, and registers the selected word onto a single output channel with a valid flag.
- Bounded grant hold gives fairness; sits between requesting sub-blocks and the shared 2-bit channel.

Parameters:
- WIDTH, 2, data width of each requester word and of out.
- MAX_HOLD, 4, maximum consecutive grant cycles while another requester waits (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; bit i belongs to requester i.
- in1  input  WIDTH  requester 0 data.
- in2  input  WIDTH  requester 1 data.
- in3  input  WIDTH  requester 2 data.
- in4  input  WIDTH  requester 3 data.
- grant  output  4  one-hot registered grant; all-zero when idle.
- select  output  2  registered index of the granted requester; drives the shared mux.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  out carries a word transferred this cycle.
- busy  output  1  high while in GRANT state.

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: grant=0000, select=0, out=0, out_valid=0, busy=0, state=IDLE, last-served pointer=3 (so requester 0 has first priority), hold_cnt=0.
- rst has priority over all other activity, including mid-grant. The cycle after rst, all outputs are at reset values regardless of req.
- Arbitration order: search req starting at (last+1) mod 4 and wrapping; pick the first set bit.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Else on the next edge: state=GRANT, grant=onehot(i), select=i, hold_cnt=1, busy=1.
  - Latency: req sampled at edge N gives grant visible after edge N.
- GRANT, with s = select. Evaluate in this priority order:
  1. req[s]==0 and another req set: switch directly to the next winner (search from s+1) on the same edge. No idle bubble. last=s, hold_cnt=1.
  2. req[s]==0 and no other req: go to IDLE. grant=0000, busy=0, last=s. select holds its value.
  3. req[s]==1, hold_cnt==MAX_HOLD, and another req set: preempt to the next winner as in case 1. last=s, hold_cnt=1.
  4. Otherwise: keep grant. hold_cnt increments and saturates at MAX_HOLD.
  - A requester alone keeps its grant indefinitely.
- Data path, evaluated at each edge:
  - out_valid <= (state==GRANT && req[select]).
  - When that term is true: out <= word of requester select (in1..in4 for select 0..3).
  - Otherwise out holds its last value.
  - So out lags grant by one cycle; a transfer is a cycle in which grant[s] and req[s] are both high.
- Data inputs are sampled only on clk. Changes to non-selected inputs never affect out. Ordering by edge fully removes the sensitivity-list hazard of a combinational mux.
- grant is always one-hot or zero. select always matches the set grant bit when busy=1.
- Simultaneous requests: round-robin order only. No fixed priority beyond the reset pointer.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=1111 -> grant=0000, out_valid=0, out=0, busy=0. After rst drops, next edge gives grant=0001, select=0.
- Single requester: req=0100, in3=2'b10 steady for 10 cycles -> grant=0100 continuously (no preemption). out=10 with out_valid=1 from the cycle after grant.
- Fairness, MAX_HOLD=4: req=1111 held constant, inputs in1..in4 = 0,1,2,3 -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 ... out follows 0,1,2,3 with one-cycle lag.
- Early release: requester 1 granted, drops req[1] while req=1001 -> next edge grant=1000 (requester 3 follows 1), no idle cycle. Then all req=0 -> IDLE, grant=0000, out_valid=0, out holds 3.
- Reset mid-grant: requester 2 granted with hold_cnt=3, assert rst for 1 cycle with req=0110 -> outputs at reset values. After release, grant=0010 (pointer restored to 3, so search starts at 0 and finds 1).
- Input isolation: requester 0 granted, toggle in2/in3/in4 every cycle -> out stays equal to in1 as sampled each edge. No glitch from non-selected inputs.
